// File: rtl/full_adder.sv
// rtl/full_adder.sv - registered ripple-carry adder, optional signed overflow via FULL_ADDER_OVERFLOW_EN
module full_adder #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] s,
  output logic             cout,
`ifdef FULL_ADDER_OVERFLOW_EN
  output logic             ovf,
`endif
  output logic             out_valid
);

  logic [WIDTH-1:0] sum_c;
  logic             carry;
`ifdef FULL_ADDER_OVERFLOW_EN
  logic             carry_msb;
`endif

  // Ripple the carry through one full-adder cell per bit; carry_msb is the carry into the MSB cell
  always_comb begin
    sum_c = '0;
    carry = cin;
`ifdef FULL_ADDER_OVERFLOW_EN
    carry_msb = cin;
`endif
    for (int i = 0; i < WIDTH; i++) begin
`ifdef FULL_ADDER_OVERFLOW_EN
      carry_msb = carry;
`endif
      sum_c[i] = a[i] ^ b[i] ^ carry;
      carry    = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
    end
  end

  // Capture the result on a valid edge, hold it otherwise; out_valid tracks in_valid one edge later
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s         <= '0;
      cout      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        s    <= sum_c;
        cout <= carry;
      end
    end
  end

`ifdef FULL_ADDER_OVERFLOW_EN
  // Two's-complement overflow: carry into the MSB differs from carry out of it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf <= 1'b0;
    end else if (in_valid) begin
      ovf <= carry ^ carry_msb;
    end
  end
`endif

endmodule

// File: tb/tb_full_adder.sv
// tb/tb_full_adder.sv - directed-vector bench for full_adder at WIDTH=1 and WIDTH=4
module tb_full_adder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       v1 = 1'b0, v4 = 1'b0;
  logic       a1 = 1'b0, b1 = 1'b0, c1 = 1'b0, cin4 = 1'b0;
  logic [3:0] a4 = '0, b4 = '0;
  logic       s1, cout1, ov1;
  logic [3:0] s4;
  logic       cout4, ov4;
`ifdef FULL_ADDER_OVERFLOW_EN
  logic       ovf1, ovf4;
`endif

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  full_adder #(.WIDTH(1)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(v1), .a(a1), .b(b1), .cin(c1),
    .s(s1), .cout(cout1),
`ifdef FULL_ADDER_OVERFLOW_EN
    .ovf(ovf1),
`endif
    .out_valid(ov1)
  );

  full_adder #(.WIDTH(4)) u4 (
    .clk(clk), .rst_n(rst_n), .in_valid(v4), .a(a4), .b(b4), .cin(cin4),
    .s(s4), .cout(cout4),
`ifdef FULL_ADDER_OVERFLOW_EN
    .ovf(ovf4),
`endif
    .out_valid(ov4)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #1;
    vectors++;
    if ({s1, cout1, ov1} !== 3'b000) begin
      miscompares++;
      $display("FAIL reset_w1 got s/cout/ov=%b required 000", {s1, cout1, ov1});
    end
    vectors++;
    if ({s4, cout4, ov4} !== 6'b000000) begin
      miscompares++;
      $display("FAIL reset_w4 got s/cout/ov=%b required 000000", {s4, cout4, ov4});
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_truth_table();
    logic [1:0] exp_tt [8] = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};
    logic [2:0] abc;
    for (int i = 0; i < 8; i++) begin
      abc = i[2:0];
      v1 = 1'b1; a1 = abc[2]; b1 = abc[1]; c1 = abc[0];
      tick();
      vectors++;
      if ({cout1, s1, ov1} !== {exp_tt[i], 1'b1}) begin
        miscompares++;
        $display("FAIL truth_%0d got cout/s/ov=%b required %b", i, {cout1, s1, ov1}, {exp_tt[i], 1'b1});
      end
    end
    v1 = 1'b0;
  endtask

  task automatic test_wrap();
    v4 = 1'b1; a4 = 4'hF; b4 = 4'h0; cin4 = 1'b1;
    tick();
    vectors++;
    if ({cout4, s4, ov4} !== {1'b1, 4'h0, 1'b1}) begin
      miscompares++;
      $display("FAIL wrap_f_0_1 got cout=%b s=%h ov=%b required cout=1 s=0 ov=1", cout4, s4, ov4);
    end
    a4 = 4'hF; b4 = 4'hF; cin4 = 1'b1;
    tick();
    vectors++;
    if ({cout4, s4} !== {1'b1, 4'hF}) begin
      miscompares++;
      $display("FAIL wrap_f_f_1 got cout=%b s=%h required cout=1 s=f", cout4, s4);
    end
    v4 = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [3:0] ta [3] = '{4'h3, 4'h8, 4'h5};
    logic [3:0] tb [3] = '{4'h4, 4'h8, 4'hA};
    logic       tc [3] = '{1'b0, 1'b0, 1'b1};
    logic [4:0] te [3] = '{5'h07, 5'h10, 5'h10};
    for (int i = 0; i < 3; i++) begin
      v4 = 1'b1; a4 = ta[i]; b4 = tb[i]; cin4 = tc[i];
      tick();
      vectors++;
      if ({cout4, s4, ov4} !== {te[i], 1'b1}) begin
        miscompares++;
        $display("FAIL b2b_%0d got cout/s=%h ov=%b required %h ov=1", i, {cout4, s4}, ov4, te[i]);
      end
    end
    v4 = 1'b0;
  endtask

  task automatic test_hold();
    v1 = 1'b1; a1 = 1'b1; b1 = 1'b1; c1 = 1'b0;
    tick();
    vectors++;
    if ({cout1, s1, ov1} !== 3'b101) begin
      miscompares++;
      $display("FAIL hold_load got cout/s/ov=%b required 101", {cout1, s1, ov1});
    end
    v1 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      a1 = ~a1; b1 = (i == 1); c1 = ~c1;
      tick();
      vectors++;
      if ({cout1, s1, ov1} !== 3'b100) begin
        miscompares++;
        $display("FAIL hold_%0d got cout/s/ov=%b required 100", i, {cout1, s1, ov1});
      end
    end
  endtask

  task automatic test_reset_midop();
    v4 = 1'b1; a4 = 4'h9; b4 = 4'h4; cin4 = 1'b1;
    tick();
    vectors++;
    if ({cout4, s4, ov4} !== {1'b0, 4'hE, 1'b1}) begin
      miscompares++;
      $display("FAIL midop_load got cout=%b s=%h ov=%b required cout=0 s=e ov=1", cout4, s4, ov4);
    end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({cout4, s4, ov4} !== 6'b000000) begin
      miscompares++;
      $display("FAIL midop_async got cout/s/ov=%b required 000000", {cout4, s4, ov4});
    end
    v4 = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      vectors++;
      if ({cout4, s4, ov4} !== 6'b000000) begin
        miscompares++;
        $display("FAIL midop_idle_%0d got cout/s/ov=%b required 000000", i, {cout4, s4, ov4});
      end
    end
    v4 = 1'b1; a4 = 4'h2; b4 = 4'h3; cin4 = 1'b0;
    tick();
    vectors++;
    if ({cout4, s4, ov4} !== {1'b0, 4'h5, 1'b1}) begin
      miscompares++;
      $display("FAIL midop_first got cout=%b s=%h ov=%b required cout=0 s=5 ov=1", cout4, s4, ov4);
    end
    v4 = 1'b0;
  endtask

`ifdef FULL_ADDER_OVERFLOW_EN
  task automatic test_overflow();
    v4 = 1'b1; a4 = 4'h7; b4 = 4'h1; cin4 = 1'b0;
    tick();
    vectors++;
    if ({cout4, s4, ovf4} !== {1'b0, 4'h8, 1'b1}) begin
      miscompares++;
      $display("FAIL ovf_7_1 got cout=%b s=%h ovf=%b required cout=0 s=8 ovf=1", cout4, s4, ovf4);
    end
    a4 = 4'hF; b4 = 4'h1; cin4 = 1'b0;
    tick();
    vectors++;
    if ({cout4, s4, ovf4} !== {1'b1, 4'h0, 1'b0}) begin
      miscompares++;
      $display("FAIL ovf_f_1 got cout=%b s=%h ovf=%b required cout=1 s=0 ovf=0", cout4, s4, ovf4);
    end
    v4 = 1'b0; a4 = 4'h7; b4 = 4'h7;
    tick();
    vectors++;
    if ({s4, ovf4} !== {4'h0, 1'b0}) begin
      miscompares++;
      $display("FAIL ovf_hold got s=%h ovf=%b required s=0 ovf=0", s4, ovf4);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_truth_table();
    test_wrap();
    test_back_to_back();
    test_hold();
    test_reset_midop();
`ifdef FULL_ADDER_OVERFLOW_EN
    test_overflow();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
